// File: rtl/dmg_link_partner.sv
// Far end of the DMG serial link cable: exchanges one byte per transfer with the DMG SB/SC port,
// either following the DMG SCK (slave) or generating SCK itself (master).
module dmg_link_partner #(
    parameter int unsigned CLK_DIV     = 16,
    parameter int unsigned TIMEOUT     = 4096,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       mode,
    input  logic       sck_in,
    input  logic       sout_from_dmg,
    output logic       sin_to_dmg,
    output logic       sck_out,
    output logic       sck_oe,
    input  logic [7:0] tx_byte,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       start,
    output logic       busy,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       timeout_err
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned TmrW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StSlaveXfer, StMasterLow, StMasterHigh} state_e;

    state_e                 state_q, state_d;
    logic                   mode_q, mode_d;
    logic [7:0]             tx_sr_q, tx_sr_d;
    logic [7:0]             rx_sr_q, rx_sr_d;
    logic [7:0]             rx_byte_q, rx_byte_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [DivW-1:0]        div_q, div_d;
    logic [TmrW-1:0]        tmr_q, tmr_d;
    logic                   sck_out_q, sck_out_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   timeout_q, timeout_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, so_sync_q;
    logic                   sck_prev_q;
    logic                   sck_s, so_s, sck_rise, sck_fall;
    logic                   xfer_rise, xfer_fall;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign so_s     = so_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_byte_d  = rx_byte_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        tmr_d      = tmr_q;
        sck_out_d  = sck_out_q;
        rx_valid_d = 1'b0;
        timeout_d  = 1'b0;
        xfer_rise  = 1'b0;
        xfer_fall  = 1'b0;

        unique case (state_q)
            StIdle: begin
                mode_d = mode;
                cnt_d  = 3'd0;
                if (tx_valid) tx_sr_d = tx_byte;
                if (mode && start) begin
                    state_d   = StMasterLow;
                    sck_out_d = 1'b0;
                    div_d     = '0;
                    xfer_fall = 1'b1;
                end else if (!mode && sck_fall) begin
                    state_d   = StSlaveXfer;
                    tmr_d     = '0;
                    xfer_fall = 1'b1;
                end
            end
            StSlaveXfer: begin
                xfer_rise = sck_rise;
                xfer_fall = sck_fall;
                tmr_d     = tmr_q + TmrW'(1);
                if (sck_rise || sck_fall) begin
                    tmr_d = '0;
                end else if (tmr_q == TmrW'(TIMEOUT - 1)) begin
                    // Partial byte is dropped; rx_byte keeps the last good value.
                    timeout_d = 1'b1;
                    cnt_d     = 3'd0;
                    rx_sr_d   = 8'h00;
                    tx_sr_d   = 8'hFF;
                    state_d   = StIdle;
                end
            end
            StMasterLow: begin
                div_d = div_q + DivW'(1);
                if (div_q == DivW'(CLK_DIV - 1)) begin
                    div_d     = '0;
                    sck_out_d = 1'b1;
                    state_d   = StMasterHigh;
                    xfer_rise = 1'b1;
                end
            end
            StMasterHigh: begin
                div_d = div_q + DivW'(1);
                if (div_q == DivW'(CLK_DIV - 1)) begin
                    div_d = '0;
                    // cnt wraps to 0 only after the 8th rising edge
                    if (cnt_q == 3'd0) begin
                        state_d = StIdle;
                        tx_sr_d = 8'hFF;
                    end else begin
                        state_d   = StMasterLow;
                        sck_out_d = 1'b0;
                        xfer_fall = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (xfer_fall && cnt_q != 3'd0) tx_sr_d = {tx_sr_q[6:0], 1'b1};

        if (xfer_rise) begin
            rx_sr_d = {rx_sr_q[6:0], so_s};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                rx_byte_d  = {rx_sr_q[6:0], so_s};
                rx_valid_d = 1'b1;
                cnt_d      = 3'd0;
                if (state_q == StSlaveXfer) begin
                    state_d = StIdle;
                    tx_sr_d = 8'hFF;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) begin
            state_q    <= StIdle;
            mode_q     <= 1'b0;
            tx_sr_q    <= 8'hFF;
            rx_sr_q    <= 8'h00;
            rx_byte_q  <= 8'h00;
            cnt_q      <= 3'd0;
            div_q      <= '0;
            tmr_q      <= '0;
            sck_out_q  <= 1'b1;
            rx_valid_q <= 1'b0;
            timeout_q  <= 1'b0;
            sck_sync_q <= '1;
            so_sync_q  <= '1;
            sck_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_byte_q  <= rx_byte_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            tmr_q      <= tmr_d;
            sck_out_q  <= sck_out_d;
            rx_valid_q <= rx_valid_d;
            timeout_q  <= timeout_d;
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck_in};
            so_sync_q  <= {so_sync_q[SYNC_STAGES-2:0], sout_from_dmg};
            sck_prev_q <= sck_s;
        end
    end

    assign sin_to_dmg  = tx_sr_q[7];
    assign sck_out     = sck_out_q;
    assign sck_oe      = (state_q == StIdle) ? mode : mode_q;
    assign tx_ready    = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign rx_byte     = rx_byte_q;
    assign rx_valid    = rx_valid_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_dmg_link_partner.sv
// Directed bench for dmg_link_partner: table of whole-byte transfers in both modes,
// plus hand-written timeout, mid-transfer reset and busy-poke sequences.
module tb_dmg_link_partner;

    localparam int unsigned CLK_DIV     = 4;
    localparam int unsigned TIMEOUT     = 200;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int          HALF        = 16;
    localparam int          NV          = 5;

    logic       clk;
    logic       nreset;
    logic       mode;
    logic       sck_in;
    logic       sout_from_dmg;
    logic       sin_to_dmg;
    logic       sck_out;
    logic       sck_oe;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;
    logic       start;
    logic       busy;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       timeout_err;

    dmg_link_partner #(
        .CLK_DIV    (CLK_DIV),
        .TIMEOUT    (TIMEOUT),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk          (clk),
        .nreset       (nreset),
        .mode         (mode),
        .sck_in       (sck_in),
        .sout_from_dmg(sout_from_dmg),
        .sin_to_dmg   (sin_to_dmg),
        .sck_out      (sck_out),
        .sck_oe       (sck_oe),
        .tx_byte      (tx_byte),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .start        (start),
        .busy         (busy),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       mode;
        bit       load;
        bit [7:0] tx;
        bit [7:0] so;
        bit [7:0] exp_rx;
        bit [7:0] exp_sin;
        int       poke;
    } vec_t;

    vec_t vecs[NV];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   rxv_cnt = 0;
    int   to_cnt  = 0;
    bit   both_seen = 1'b0;

    always @(negedge clk) begin
        if (rx_valid) rxv_cnt++;
        if (timeout_err) to_cnt++;
        if (rx_valid && timeout_err) both_seen = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Acts as the DMG clocking SCK; SO changes with each fall, SI sampled just before each rise.
    task automatic slave_xfer(input bit load, input logic [7:0] tx, input logic [7:0] so,
                              input int nbits, output logic [7:0] sin_seen,
                              output bit oe_ok, output bit busy_ok);
        logic [2:0] bi;
        mode     = 1'b0;
        sin_seen = 8'h00;
        oe_ok    = 1'b1;
        busy_ok  = 1'b1;
        if (load) begin
            tx_byte  = tx;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
        end
        for (int i = 0; i < nbits; i++) begin
            bi            = 3'(7 - i);
            sck_in        = 1'b0;
            sout_from_dmg = so[bi];
            repeat (HALF) @(negedge clk);
            sin_seen[bi] = sin_to_dmg;
            if (sck_oe) oe_ok = 1'b0;
            if (!busy) busy_ok = 1'b0;
            sck_in = 1'b1;
            repeat (HALF) @(negedge clk);
        end
    endtask

    // Acts as the DMG in external-clock mode; optionally pokes tx_valid/start/mode while busy.
    task automatic master_xfer(input bit load, input logic [7:0] tx, input logic [7:0] so,
                               input int poke, output logic [7:0] sin_seen, output int rises,
                               output bit per_ok, output bit oe_ok, output bit rdy_ok,
                               output int tail, output bit done);
        logic       prev;
        logic [2:0] bi;
        int         last_rise;
        sin_seen  = 8'h00;
        rises     = 0;
        per_ok    = 1'b1;
        oe_ok     = 1'b1;
        rdy_ok    = 1'b1;
        tail      = -1;
        done      = 1'b0;
        last_rise = -1;
        mode      = 1'b1;
        if (load) begin
            tx_byte  = tx;
            tx_valid = 1'b1;
        end
        start = 1'b1;
        prev  = sck_out;
        @(negedge clk);
        tx_valid = 1'b0;
        start    = 1'b0;
        for (int c = 1; c < 1000; c++) begin
            bi = 3'(7 - rises);
            if (busy && tx_ready) rdy_ok = 1'b0;
            if (busy && !sck_oe) oe_ok = 1'b0;
            if (prev && !sck_out && rises < 8) sout_from_dmg = so[bi];
            if (!prev && sck_out) begin
                if (rises < 8) sin_seen[bi] = sin_to_dmg;
                if (last_rise >= 0 && c - last_rise != 2 * CLK_DIV) per_ok = 1'b0;
                last_rise = c;
                rises++;
            end
            if (!busy) begin
                tail = c - last_rise;
                done = 1'b1;
                break;
            end
            prev = sck_out;
            if (c == poke) begin
                tx_byte  = 8'h00;
                tx_valid = 1'b1;
                start    = 1'b1;
                mode     = 1'b0;
            end else if (c == poke + 1) begin
                tx_valid = 1'b0;
                start    = 1'b0;
            end
            @(negedge clk);
        end
        tx_valid = 1'b0;
        start    = 1'b0;
    endtask

    initial begin
        logic [7:0] sin_seen;
        int         rises, tail, rv0, tv0, hit, r;
        bit         per_ok, oe_ok, rdy_ok, done, busy_ok;
        logic       prev;

        vecs[0] = '{1'b0, 1'b1, 8'hA5, 8'h3C, 8'h3C, 8'hA5, -1};
        vecs[1] = '{1'b1, 1'b1, 8'h81, 8'h00, 8'h00, 8'h81, -1};
        vecs[2] = '{1'b0, 1'b0, 8'h00, 8'hFF, 8'hFF, 8'hFF, -1};
        vecs[3] = '{1'b1, 1'b1, 8'h3C, 8'hC3, 8'hC3, 8'h3C, 20};
        vecs[4] = '{1'b0, 1'b1, 8'h5A, 8'h96, 8'h96, 8'h5A, -1};

        nreset        = 1'b1;
        mode          = 1'b0;
        sck_in        = 1'b1;
        sout_from_dmg = 1'b1;
        tx_byte       = 8'h00;
        tx_valid      = 1'b0;
        start         = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sin", 32'(sin_to_dmg), 1);
        check("rst_sck_out", 32'(sck_out), 1);
        check("rst_sck_oe", 32'(sck_oe), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_tx_ready", 32'(tx_ready), 1);
        check("rst_rx_byte", 32'(rx_byte), 0);
        check("rst_pulses", 32'({rx_valid, timeout_err}), 0);
        nreset = 1'b0;
        repeat (3) @(negedge clk);

        for (int v = 0; v < NV; v++) begin
            rv0 = rxv_cnt;
            if (vecs[v].mode) begin
                master_xfer(vecs[v].load, vecs[v].tx, vecs[v].so, vecs[v].poke, sin_seen, rises,
                            per_ok, oe_ok, rdy_ok, tail, done);
                check($sformatf("v%0d_done", v), 32'(done), 1);
                check($sformatf("v%0d_rises", v), 32'(rises), 8);
                check($sformatf("v%0d_period", v), 32'(per_ok), 1);
                check($sformatf("v%0d_tail", v), 32'(tail), CLK_DIV);
                check($sformatf("v%0d_oe", v), 32'(oe_ok), 1);
                check($sformatf("v%0d_ready_low", v), 32'(rdy_ok), 1);
            end else begin
                slave_xfer(vecs[v].load, vecs[v].tx, vecs[v].so, 8, sin_seen, oe_ok, busy_ok);
                check($sformatf("v%0d_oe", v), 32'(oe_ok), 1);
                check($sformatf("v%0d_busy", v), 32'(busy_ok), 1);
            end
            repeat (4) @(negedge clk);
            check($sformatf("v%0d_rx_byte", v), 32'(rx_byte), 32'(vecs[v].exp_rx));
            check($sformatf("v%0d_rx_valid_cycles", v), 32'(rxv_cnt - rv0), 1);
            check($sformatf("v%0d_sin_seq", v), 32'(sin_seen), 32'(vecs[v].exp_sin));
            check($sformatf("v%0d_idle_busy", v), 32'(busy), 0);
            check($sformatf("v%0d_idle_ready", v), 32'(tx_ready), 1);
        end

        // Slave SCK stops after 3 bits: abort exactly TIMEOUT clk after the last synced edge.
        rv0 = rxv_cnt;
        tv0 = to_cnt;
        hit = -1;
        slave_xfer(1'b0, 8'h00, 8'hE0, 3, sin_seen, oe_ok, busy_ok);
        for (int c = HALF; c < HALF + int'(TIMEOUT) + 50; c++) begin
            @(negedge clk);
            if (timeout_err) begin
                hit = c + 1;
                break;
            end
        end
        check("to_latency", 32'(hit), TIMEOUT + SYNC_STAGES + 1);
        @(negedge clk);
        check("to_pulse_width", 32'(timeout_err), 0);
        check("to_count", 32'(to_cnt - tv0), 1);
        check("to_no_rx_valid", 32'(rxv_cnt - rv0), 0);
        check("to_rx_byte_kept", 32'(rx_byte), 32'(vecs[NV-1].exp_rx));
        check("to_idle", 32'(busy), 0);
        rv0 = rxv_cnt;
        slave_xfer(1'b0, 8'h00, 8'h69, 8, sin_seen, oe_ok, busy_ok);
        repeat (4) @(negedge clk);
        check("to_next_rx", 32'(rx_byte), 32'h69);
        check("to_next_rx_valid", 32'(rxv_cnt - rv0), 1);
        check("to_next_sin", 32'(sin_seen), 32'hFF);

        // Reset during the 6th low half of a master transfer of 8'hC3 (SI shows bit 2 = 0).
        mode     = 1'b1;
        tx_byte  = 8'hC3;
        tx_valid = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        start    = 1'b0;
        r        = 0;
        prev     = sck_out;
        for (int c = 0; c < 500 && r < 5; c++) begin
            @(negedge clk);
            if (!prev && sck_out) r++;
            prev = sck_out;
        end
        check("rstx_rises", 32'(r), 5);
        repeat (CLK_DIV + 1) @(negedge clk);
        check("rstx_pre_sck", 32'(sck_out), 0);
        check("rstx_pre_sin", 32'(sin_to_dmg), 0);
        nreset = 1'b1;
        #1;
        check("rstx_sck_out", 32'(sck_out), 1);
        check("rstx_sin", 32'(sin_to_dmg), 1);
        check("rstx_busy", 32'(busy), 0);
        check("rstx_rx_byte", 32'(rx_byte), 0);
        @(negedge clk);
        nreset = 1'b0;
        @(negedge clk);
        rv0 = rxv_cnt;
        master_xfer(1'b1, 8'h5A, 8'h96, -1, sin_seen, rises, per_ok, oe_ok, rdy_ok, tail, done);
        repeat (4) @(negedge clk);
        check("post_rst_done", 32'(done), 1);
        check("post_rst_sin", 32'(sin_seen), 32'h5A);
        check("post_rst_rx", 32'(rx_byte), 32'h96);
        check("post_rst_rx_valid", 32'(rxv_cnt - rv0), 1);

        check("never_both_pulses", 32'(both_seen), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
